// File: rtl/riscv_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// riscv_multicycle_ctrl
//
// Multi-cycle control FSM for a RISC-V style datapath with a shared memory
// port and a single ALU. Each instruction steps through FETCH, DECODE, EXEC,
// MEM and WB as needed. The FSM emits the datapath strobes for the current
// cycle, waits on the memory ready handshake with a timeout, and locks into
// ERR on an illegal opcode or a memory timeout.
//
// Parameters
//   MEM_TIMEOUT   consecutive cycles mem_req may stay high without mem_ready
//                 before the FSM gives up and enters ERR (1..255)
//   SUPPORT_JUMP  1: JAL/JALR/LUI/AUIPC are legal, 0: they decode as illegal
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   op            IR[6:0], valid from DECODE onward
//   mem_ready     memory completes this cycle (read data valid same cycle)
//   mem_req       memory access request; mem_we qualifies it as a store
//   adr_src       0: address = PC, 1: address = ALU result register
//   ir_write      load IR from memory read data
//   pc_write      unconditional PC update
//   branch        PC update if ALU zero (gated in the datapath)
//   alu_src_a     00 PC, 01 rs1, 10 zero, 11 old PC
//   alu_src_b     00 rs2, 01 imm, 10 constant 4
//   alu_op        00 add, 01 sub/compare, 10 funct-decoded
//   result_src    00 ALU result register, 01 memory data, 10 PC+4
//   reg_write     register file write enable
//   err           sticky error flag (illegal opcode or memory timeout)
//   state_o       current state, for debug
//   instr_done    one-cycle pulse on the last cycle of each instruction
//
// State, latched opcode, wait counter and error flag live in one clocked
// block. The strobes are decoded from those registers; ir_write, pc_write and
// the store's instr_done are additionally qualified by mem_ready because the
// read data is only valid in the cycle the memory answers. All outputs are
// forced low while rst is asserted.
// -----------------------------------------------------------------------------
module riscv_multicycle_ctrl #(
    parameter int MEM_TIMEOUT  = 16,
    parameter bit SUPPORT_JUMP = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       branch,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic       reg_write,
    output logic       err,
    output logic [2:0] state_o,
    output logic       instr_done
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_R, C_I, C_LOAD, C_STORE, C_BRANCH,
        C_JAL, C_JALR, C_LUI, C_AUIPC, C_ILLEGAL
    } op_class_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    // Jump-family opcodes fall through to illegal when jump support is off.
    function automatic op_class_t classify(input logic [6:0] opc);
        op_class_t c;
        c = C_ILLEGAL;
        case (opc)
            OP_R:      c = C_R;
            OP_I:      c = C_I;
            OP_LOAD:   c = C_LOAD;
            OP_STORE:  c = C_STORE;
            OP_BRANCH: c = C_BRANCH;
            OP_JAL:    c = SUPPORT_JUMP ? C_JAL   : C_ILLEGAL;
            OP_JALR:   c = SUPPORT_JUMP ? C_JALR  : C_ILLEGAL;
            OP_LUI:    c = SUPPORT_JUMP ? C_LUI   : C_ILLEGAL;
            OP_AUIPC:  c = SUPPORT_JUMP ? C_AUIPC : C_ILLEGAL;
            default:   c = C_ILLEGAL;
        endcase
        return c;
    endfunction

    state_t     state;
    logic [6:0] op_q;
    logic [7:0] wait_cnt;
    logic       err_q;

    op_class_t  cls_in;
    op_class_t  cls_q;
    logic       mem_phase;
    logic       timeout_hit;

    assign cls_in    = classify(op);
    assign cls_q     = classify(op_q);
    assign mem_phase = (state == S_FETCH) || (state == S_MEM);

    // wait_cnt holds the number of earlier unanswered cycles, so this cycle
    // is the last permitted one when wait_cnt + 1 reaches the limit. A ready
    // in that same cycle still wins because the ready branch is taken first.
    assign timeout_hit = mem_phase && !mem_ready && ((wait_cnt + 8'd1) == TIMEOUT);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values and the update order inside the block does
    // not matter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FETCH;
            op_q     <= 7'd0;
            wait_cnt <= 8'd0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (mem_ready) begin
                        state    <= S_DECODE;
                        wait_cnt <= 8'd0;
                    end else if (timeout_hit) begin
                        state    <= S_ERR;
                        err_q    <= 1'b1;
                        wait_cnt <= 8'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end

                S_DECODE: begin
                    op_q <= op;
                    if (cls_in == C_ILLEGAL) begin
                        state <= S_ERR;
                        err_q <= 1'b1;
                    end else begin
                        state <= S_EXEC;
                    end
                end

                S_EXEC: begin
                    case (cls_q)
                        C_LOAD, C_STORE: state <= S_MEM;
                        C_BRANCH:        state <= S_FETCH;
                        C_ILLEGAL: begin
                            state <= S_ERR;
                            err_q <= 1'b1;
                        end
                        default:         state <= S_WB;
                    endcase
                end

                S_MEM: begin
                    if (mem_ready) begin
                        state    <= (cls_q == C_STORE) ? S_FETCH : S_WB;
                        wait_cnt <= 8'd0;
                    end else if (timeout_hit) begin
                        state    <= S_ERR;
                        err_q    <= 1'b1;
                        wait_cnt <= 8'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end

                S_WB: state <= S_FETCH;

                S_ERR: state <= S_ERR;

                default: begin
                    state <= S_ERR;
                    err_q <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        // NOTE: every output takes a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        result_src = 2'b00;
        reg_write  = 1'b0;
        err        = 1'b0;
        state_o    = 3'd0;
        instr_done = 1'b0;

        if (!rst) begin
            state_o = state;
            err     = err_q;
            case (state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    adr_src = 1'b0;
                    // PC <= PC + 4 in the same cycle the instruction word lands.
                    if (mem_ready) begin
                        ir_write  = 1'b1;
                        pc_write  = 1'b1;
                        alu_src_a = 2'b00;
                        alu_src_b = 2'b10;
                        alu_op    = 2'b00;
                    end
                end

                S_DECODE: begin
                    // Precompute old PC + imm so a branch can use it in EXEC.
                    alu_src_a = 2'b11;
                    alu_src_b = 2'b01;
                    alu_op    = 2'b00;
                end

                S_EXEC: begin
                    case (cls_q)
                        C_R: begin
                            alu_src_a = 2'b01;
                            alu_src_b = 2'b00;
                            alu_op    = 2'b10;
                        end
                        C_I: begin
                            alu_src_a = 2'b01;
                            alu_src_b = 2'b01;
                            alu_op    = 2'b10;
                        end
                        C_LOAD, C_STORE: begin
                            alu_src_a = 2'b01;
                            alu_src_b = 2'b01;
                            alu_op    = 2'b00;
                        end
                        C_BRANCH: begin
                            alu_src_a  = 2'b01;
                            alu_src_b  = 2'b00;
                            alu_op     = 2'b01;
                            branch     = 1'b1;
                            instr_done = 1'b1;
                        end
                        C_JAL: begin
                            pc_write  = 1'b1;
                            alu_src_a = 2'b11;
                            alu_src_b = 2'b01;
                        end
                        C_JALR: begin
                            pc_write  = 1'b1;
                            alu_src_a = 2'b01;
                            alu_src_b = 2'b01;
                        end
                        C_LUI: begin
                            alu_src_a = 2'b10;
                            alu_src_b = 2'b01;
                        end
                        C_AUIPC: begin
                            alu_src_a = 2'b11;
                            alu_src_b = 2'b01;
                        end
                        default: ;
                    endcase
                end

                S_MEM: begin
                    mem_req    = 1'b1;
                    adr_src    = 1'b1;
                    mem_we     = (cls_q == C_STORE);
                    instr_done = (cls_q == C_STORE) && mem_ready;
                end

                S_WB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                    case (cls_q)
                        C_LOAD:         result_src = 2'b01;
                        C_JAL, C_JALR:  result_src = 2'b10;
                        default:        result_src = 2'b00;
                    endcase
                end

                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_riscv_multicycle_ctrl
//
// Three controller instances share one set of inputs: the default build, a
// build with a short memory timeout and a build without jump support. A table
// of hand-derived vectors and a few hand-written sequences check the corner
// cases; a randomized run then compares the default build each cycle against
// a model that tracks the remaining steps of the current instruction in a
// queue.
// -----------------------------------------------------------------------------
module tb_riscv_multicycle_ctrl;

    localparam int T_MAIN = 16;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_ILL = 7'b1111111;

    typedef struct packed {
        logic [2:0] st;
        logic       req, we, adr, irw, pcw, br;
        logic [1:0] a, b, aop, rs;
        logic       rw, er, dn;
    } out_t;

    typedef struct {
        logic       r;
        logic [6:0] op;
        logic       rdy;
        out_t       exp;
    } vec_t;

    typedef enum {
        K_FETCH, K_DECODE, K_EX_R, K_EX_I, K_EX_LS, K_EX_BR, K_EX_JAL,
        K_EX_JALR, K_EX_LUI, K_EX_AUIPC, K_MEM_LD, K_MEM_ST,
        K_WB_ALU, K_WB_LD, K_WB_PC, K_ERR
    } step_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op = 7'd0;
    logic       mem_ready = 1'b0;

    logic       req_m, we_m, adr_m, irw_m, pcw_m, br_m, rw_m, err_m, done_m;
    logic [1:0] a_m, b_m, aop_m, rs_m;
    logic [2:0] st_m;
    logic       req_t, we_t, adr_t, irw_t, pcw_t, br_t, rw_t, err_t, done_t;
    logic [1:0] a_t, b_t, aop_t, rs_t;
    logic [2:0] st_t;
    logic       req_n, we_n, adr_n, irw_n, pcw_n, br_n, rw_n, err_n, done_n;
    logic [1:0] a_n, b_n, aop_n, rs_n;
    logic [2:0] st_n;

    out_t got_m;
    assign got_m = {st_m, req_m, we_m, adr_m, irw_m, pcw_m, br_m,
                    a_m, b_m, aop_m, rs_m, rw_m, err_m, done_m};

    int n_cmp = 0;
    int n_bad = 0;

    step_t q[$];
    int    cnt;

    always #5 clk = ~clk;

    riscv_multicycle_ctrl #(.MEM_TIMEOUT(T_MAIN), .SUPPORT_JUMP(1'b1)) dut (
        .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
        .mem_req(req_m), .mem_we(we_m), .adr_src(adr_m), .ir_write(irw_m),
        .pc_write(pcw_m), .branch(br_m), .alu_src_a(a_m), .alu_src_b(b_m),
        .alu_op(aop_m), .result_src(rs_m), .reg_write(rw_m), .err(err_m),
        .state_o(st_m), .instr_done(done_m));

    riscv_multicycle_ctrl #(.MEM_TIMEOUT(4), .SUPPORT_JUMP(1'b1)) dut_t (
        .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
        .mem_req(req_t), .mem_we(we_t), .adr_src(adr_t), .ir_write(irw_t),
        .pc_write(pcw_t), .branch(br_t), .alu_src_a(a_t), .alu_src_b(b_t),
        .alu_op(aop_t), .result_src(rs_t), .reg_write(rw_t), .err(err_t),
        .state_o(st_t), .instr_done(done_t));

    riscv_multicycle_ctrl #(.MEM_TIMEOUT(T_MAIN), .SUPPORT_JUMP(1'b0)) dut_nj (
        .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
        .mem_req(req_n), .mem_we(we_n), .adr_src(adr_n), .ir_write(irw_n),
        .pc_write(pcw_n), .branch(br_n), .alu_src_a(a_n), .alu_src_b(b_n),
        .alu_op(aop_n), .result_src(rs_n), .reg_write(rw_n), .err(err_n),
        .state_o(st_n), .instr_done(done_n));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs just after the rising edge and stop at the
    // falling edge, where outputs for this cycle are stable.
    task automatic tick(input logic r, input logic [6:0] o, input logic rdy);
        @(posedge clk);
        #1;
        rst       = r;
        op        = o;
        mem_ready = rdy;
        @(negedge clk);
    endtask

    function automatic out_t mk(input int st, input bit req, input bit we, input bit adr,
                                input bit irw, input bit pcw, input bit br, input int a,
                                input int b, input int aop, input int rs, input bit rw,
                                input bit er, input bit dn);
        out_t o;
        o.st = 3'(st); o.req = req; o.we = we; o.adr = adr; o.irw = irw; o.pcw = pcw;
        o.br = br; o.a = 2'(a); o.b = 2'(b); o.aop = 2'(aop); o.rs = 2'(rs);
        o.rw = rw; o.er = er; o.dn = dn;
        return o;
    endfunction

    // Expected strobes for one instruction step, read straight off the
    // per-state output rules.
    function automatic out_t expect_out(input step_t s, input logic rdy);
        out_t o;
        o = '0;
        case (s)
            K_FETCH: begin
                o.st = 3'd0; o.req = 1'b1;
                if (rdy) begin o.irw = 1'b1; o.pcw = 1'b1; o.b = 2'b10; end
            end
            K_DECODE:   begin o.st = 3'd1; o.a = 2'b11; o.b = 2'b01; end
            K_EX_R:     begin o.st = 3'd2; o.a = 2'b01; o.aop = 2'b10; end
            K_EX_I:     begin o.st = 3'd2; o.a = 2'b01; o.b = 2'b01; o.aop = 2'b10; end
            K_EX_LS:    begin o.st = 3'd2; o.a = 2'b01; o.b = 2'b01; end
            K_EX_BR:    begin o.st = 3'd2; o.a = 2'b01; o.aop = 2'b01; o.br = 1'b1; o.dn = 1'b1; end
            K_EX_JAL:   begin o.st = 3'd2; o.pcw = 1'b1; o.a = 2'b11; o.b = 2'b01; end
            K_EX_JALR:  begin o.st = 3'd2; o.pcw = 1'b1; o.a = 2'b01; o.b = 2'b01; end
            K_EX_LUI:   begin o.st = 3'd2; o.a = 2'b10; o.b = 2'b01; end
            K_EX_AUIPC: begin o.st = 3'd2; o.a = 2'b11; o.b = 2'b01; end
            K_MEM_LD:   begin o.st = 3'd3; o.req = 1'b1; o.adr = 1'b1; end
            K_MEM_ST:   begin o.st = 3'd3; o.req = 1'b1; o.adr = 1'b1; o.we = 1'b1; o.dn = rdy; end
            K_WB_ALU:   begin o.st = 3'd4; o.rw = 1'b1; o.dn = 1'b1; o.rs = 2'b00; end
            K_WB_LD:    begin o.st = 3'd4; o.rw = 1'b1; o.dn = 1'b1; o.rs = 2'b01; end
            K_WB_PC:    begin o.st = 3'd4; o.rw = 1'b1; o.dn = 1'b1; o.rs = 2'b10; end
            K_ERR:      begin o.st = 3'd5; o.er = 1'b1; end
            default:    o = '0;
        endcase
        return o;
    endfunction

    // Queue the remaining steps of an instruction once its opcode is known.
    task automatic push_class(input logic [6:0] o);
        case (o)
            7'b0110011: begin q.push_back(K_EX_R);     q.push_back(K_WB_ALU); end
            7'b0010011: begin q.push_back(K_EX_I);     q.push_back(K_WB_ALU); end
            7'b0000011: begin q.push_back(K_EX_LS);    q.push_back(K_MEM_LD); q.push_back(K_WB_LD); end
            7'b0100011: begin q.push_back(K_EX_LS);    q.push_back(K_MEM_ST); end
            7'b1100011: begin q.push_back(K_EX_BR); end
            7'b1101111: begin q.push_back(K_EX_JAL);   q.push_back(K_WB_PC); end
            7'b1100111: begin q.push_back(K_EX_JALR);  q.push_back(K_WB_PC); end
            7'b0110111: begin q.push_back(K_EX_LUI);   q.push_back(K_WB_ALU); end
            7'b0010111: begin q.push_back(K_EX_AUIPC); q.push_back(K_WB_ALU); end
            default: begin q.delete(); q.push_back(K_ERR); end
        endcase
    endtask

    // Advance the model by one clock: memory steps retire on ready and count
    // consecutive unanswered cycles, giving up once the count hits the limit.
    task automatic model_step(input logic r, input logic [6:0] o, input logic rdy);
        if (r) begin
            q.delete();
            q.push_back(K_FETCH);
            q.push_back(K_DECODE);
            cnt = 0;
            return;
        end
        case (q[0])
            K_ERR: ;
            K_FETCH, K_MEM_LD, K_MEM_ST: begin
                if (rdy) begin
                    void'(q.pop_front());
                    cnt = 0;
                end else begin
                    cnt++;
                    if (cnt == T_MAIN) begin
                        q.delete();
                        q.push_back(K_ERR);
                        cnt = 0;
                    end
                end
            end
            K_DECODE: begin
                void'(q.pop_front());
                push_class(o);
            end
            default: void'(q.pop_front());
        endcase
        if (q.size() == 0) begin
            q.push_back(K_FETCH);
            q.push_back(K_DECODE);
        end
    endtask

    initial begin
        vec_t  vt[24];
        out_t  fet_r, dec, wb_alu, ex_ls, mem_w;
        logic [6:0] legal_ops[9];
        logic [6:0] o;
        logic r, rdy;
        int stall;

        fet_r  = mk(0, 1, 0, 0, 1, 1, 0, 0, 2, 0, 0, 0, 0, 0);
        dec    = mk(1, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0);
        wb_alu = mk(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        ex_ls  = mk(2, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        mem_w  = mk(3, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        vt[0]  = '{1'b1, OP_R,   1'b1, out_t'(0)};
        vt[1]  = '{1'b0, OP_R,   1'b1, fet_r};
        vt[2]  = '{1'b0, OP_R,   1'b1, dec};
        vt[3]  = '{1'b0, OP_R,   1'b1, mk(2, 0, 0, 0, 0, 0, 0, 1, 0, 2, 0, 0, 0, 0)};
        vt[4]  = '{1'b0, OP_R,   1'b1, wb_alu};
        vt[5]  = '{1'b0, OP_BR,  1'b1, fet_r};
        vt[6]  = '{1'b0, OP_BR,  1'b1, dec};
        vt[7]  = '{1'b0, OP_BR,  1'b1, mk(2, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 1)};
        vt[8]  = '{1'b0, OP_LD,  1'b1, fet_r};
        vt[9]  = '{1'b0, OP_LD,  1'b1, dec};
        vt[10] = '{1'b0, OP_LD,  1'b0, ex_ls};
        vt[11] = '{1'b0, OP_LD,  1'b0, mem_w};
        vt[12] = '{1'b0, OP_LD,  1'b0, mem_w};
        vt[13] = '{1'b0, OP_LD,  1'b0, mem_w};
        vt[14] = '{1'b0, OP_LD,  1'b1, mem_w};
        vt[15] = '{1'b0, OP_LD,  1'b1, mk(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1)};
        vt[16] = '{1'b0, OP_I,   1'b1, fet_r};
        vt[17] = '{1'b0, OP_I,   1'b1, dec};
        vt[18] = '{1'b0, OP_I,   1'b1, mk(2, 0, 0, 0, 0, 0, 0, 1, 1, 2, 0, 0, 0, 0)};
        vt[19] = '{1'b0, OP_I,   1'b1, wb_alu};
        vt[20] = '{1'b0, OP_JAL, 1'b1, fet_r};
        vt[21] = '{1'b0, OP_JAL, 1'b1, dec};
        vt[22] = '{1'b0, OP_JAL, 1'b1, mk(2, 0, 0, 0, 0, 1, 0, 3, 1, 0, 0, 0, 0, 0)};
        vt[23] = '{1'b0, OP_JAL, 1'b1, mk(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 1)};

        legal_ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                      7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

        // Table: R, branch, load with a 3-cycle memory stall, I and JAL.
        for (int i = 0; i < 24; i++) begin
            tick(vt[i].r, vt[i].op, vt[i].rdy);
            check($sformatf("vec%0d", i), 32'(got_m), 32'(vt[i].exp));
        end

        // Illegal opcode locks into ERR until reset.
        tick(1'b1, OP_ILL, 1'b1);
        tick(1'b0, OP_ILL, 1'b1);
        tick(1'b0, OP_ILL, 1'b1);
        tick(1'b0, OP_ILL, 1'b1);
        check("ill_err", 32'({st_m, err_m, req_m}), 32'({3'd5, 1'b1, 1'b0}));
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, OP_R, 1'b1);
            check("ill_sticky", 32'(got_m), 32'(mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)));
        end
        tick(1'b1, OP_R, 1'b1);
        check("ill_rst_out", 32'(got_m), 32'd0);
        tick(1'b0, OP_R, 1'b0);
        check("ill_recover", 32'({st_m, err_m, req_m}), 32'({3'd0, 1'b0, 1'b1}));

        // JAL is illegal without jump support but legal in the default build.
        tick(1'b0, OP_JAL, 1'b1);
        tick(1'b0, OP_JAL, 1'b1);
        tick(1'b0, OP_JAL, 1'b1);
        check("nojump_err", 32'({st_n, err_n}), 32'({3'd5, 1'b1}));
        check("jump_exec", 32'({st_m, pcw_m, err_m}), 32'({3'd2, 1'b1, 1'b0}));

        // Fetch timeout with a limit of 4.
        tick(1'b1, OP_R, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, OP_R, 1'b0);
            check("to_fetch_hold", 32'({st_t, req_t, adr_t, err_t}), 32'({3'd0, 1'b1, 1'b0, 1'b0}));
        end
        tick(1'b0, OP_R, 1'b0);
        check("to_fetch_err", 32'({st_t, err_t}), 32'({3'd5, 1'b1}));

        // Ready on the fourth cycle is still accepted.
        tick(1'b1, OP_R, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b0, OP_R, 1'b0);
        tick(1'b0, OP_R, 1'b1);
        check("to_last_ready", 32'({st_t, irw_t}), 32'({3'd0, 1'b1}));
        tick(1'b0, OP_R, 1'b0);
        check("to_no_err", 32'({st_t, err_t}), 32'({3'd1, 1'b0}));

        // Memory-phase timeout with a limit of 4.
        tick(1'b1, OP_LD, 1'b1);
        tick(1'b0, OP_LD, 1'b1);
        tick(1'b0, OP_LD, 1'b1);
        tick(1'b0, OP_LD, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, OP_LD, 1'b0);
            check("to_mem_hold", 32'({st_t, req_t, adr_t}), 32'({3'd3, 1'b1, 1'b1}));
        end
        tick(1'b0, OP_LD, 1'b0);
        check("to_mem_err", 32'({st_t, err_t}), 32'({3'd5, 1'b1}));

        // Reset in the middle of a store's memory wait.
        tick(1'b1, OP_ST, 1'b1);
        tick(1'b0, OP_ST, 1'b1);
        tick(1'b0, OP_ST, 1'b1);
        tick(1'b0, OP_ST, 1'b0);
        tick(1'b0, OP_ST, 1'b0);
        check("st_mem", 32'({st_m, req_m, we_m, adr_m, done_m}), 32'({3'd3, 1'b1, 1'b1, 1'b1, 1'b0}));
        tick(1'b1, OP_ST, 1'b0);
        check("st_rst_out", 32'(got_m), 32'd0);
        tick(1'b0, OP_ST, 1'b0);
        check("st_after_rst", 32'({st_m, req_m, we_m, adr_m}), 32'({3'd0, 1'b1, 1'b0, 1'b0}));

        // Randomized run against the step-queue model.
        tick(1'b1, OP_R, 1'b1);
        model_step(1'b1, OP_R, 1'b1);
        stall = 0;
        for (int i = 0; i < 4000; i++) begin
            r = ($urandom_range(0, 59) == 0);
            if (stall > 0) begin
                rdy = 1'b0;
                stall--;
            end else begin
                rdy = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 149) == 0) stall = $urandom_range(10, 20);
            end
            if ($urandom_range(0, 29) == 0) o = 7'($urandom);
            else o = legal_ops[$urandom_range(0, 8)];
            tick(r, o, rdy);
            check("rand", 32'(got_m), r ? 32'd0 : 32'(expect_out(q[0], rdy)));
            model_step(r, o, rdy);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
